// File: rtl/rom_stream_ctrl.sv
// rom_stream_ctrl: fetches a burst of consecutive ROM words (wrapping at the top) and streams them over valid/ready
// Ports: start/start_addr/length command the burst; busy is high outside IDLE; done pulses once per completed burst;
// rom_address/rom_sel/rom_data talk to a combinational ROM; out_data/out_valid/out_ready/out_last form the stream.
module rom_stream_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_sel,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;
  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0] remaining;
  logic hs, final_word;
  assign hs = out_valid && out_ready;
  assign final_word = remaining == REM_ONE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign rom_sel = state == FETCH;
  assign rom_address = ptr;
  assign out_last = out_valid && final_word;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start ? (length == '0 ? DONE : FETCH) : IDLE;
      FETCH: state_n = HOLD;
      HOLD:  state_n = hs ? (final_word ? DONE : FETCH) : HOLD;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        ptr       <= start_addr;
        remaining <= length > DEPTH ? DEPTH : length;
      end
      if (state == FETCH) begin
        out_data  <= rom_data;
        out_valid <= 1'b1;
      end
      if (state == HOLD && hs) begin
        out_valid <= 1'b0;
        if (!final_word) begin
          ptr       <= ptr + ADDR_W'(1);
          remaining <= remaining - REM_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_rom_stream_ctrl.sv
// tb_rom_stream_ctrl: directed checks of rom_stream_ctrl against a behavioural ROM
module tb_rom_stream_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [2:0] start_addr = '0;
  logic [3:0] length = '0;
  logic out_ready = 1'b1;
  logic busy, done, rom_sel, out_valid, out_last;
  logic [2:0] rom_address;
  logic [7:0] rom_data, out_data;
  int checks = 0;
  int failures = 0;
  logic [7:0] words [16];
  bit lasts [16];
  int hcyc [16];
  int n, dones, dcyc, sel_seen, stable_err, stalls;

  rom_stream_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .rom_address(rom_address), .rom_sel(rom_sel),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;
  assign rom_data = rom_sel ? 8'hA0 + {5'd0, rom_address} : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [2:0] a, input logic [3:0] l);
    start = 1'b1;
    start_addr = a;
    length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready high one cycle in three. poke: cycle of a stray start.
  task automatic run(input int budget, input int mode, input int poke);
    logic pv, pr;
    logic [7:0] pd;
    n = 0; dones = 0; dcyc = -1; sel_seen = 0; stable_err = 0; stalls = 0;
    pv = 1'b0; pr = 1'b0; pd = '0;
    for (int i = 0; i < 16; i++) begin words[i] = '0; lasts[i] = 1'b0; hcyc[i] = -1; end
    for (int c = 0; c < budget; c++) begin
      out_ready = mode == 0 ? 1'b1 : (c % 3 == 2);
      start = c == poke;
      start_addr = c == poke ? 3'd5 : start_addr;
      if (rom_sel) sel_seen++;
      if (pv && !pr) begin
        stalls++;
        if (!out_valid || out_data !== pd) stable_err++;
      end
      if (out_valid && out_ready && n < 16) begin
        words[n] = out_data; lasts[n] = out_last; hcyc[n] = c; n++;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      if (done) begin dones++; dcyc = c; break; end
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_words(input string tag, input int base, input int cnt);
    check({tag, "_count"}, n, cnt);
    check({tag, "_done"}, dones, 1);
    for (int i = 0; i < cnt; i++) begin
      check($sformatf("%s_w%0d", tag, i), {24'd0, words[i]}, {24'd0, 8'hA0 + 8'((base + i) % 8)});
      check($sformatf("%s_last%0d", tag, i), {31'd0, lasts[i]}, {31'd0, i == cnt - 1});
    end
  endtask

  initial begin
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sel", rom_sel, 0);
    check("rst_done", done, 0);
    check("rst_addr", rom_address, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    go(3'd0, 4'd5);
    check("t2_sel_first", rom_sel, 1);
    check("t2_busy", busy, 1);
    run(60, 0, -1);
    check_words("t2", 0, 5);
    check("t2_first_valid", hcyc[0], 1);
    check("t2_rate", hcyc[4] - hcyc[0], 8);
    check("t2_done_cyc", dcyc, hcyc[4] + 1);
    @(negedge clk);
    check("t2_busy_after", busy, 0);
    check("t2_data_hold", out_data, 8'hA4);

    go(3'd6, 4'd4);
    run(80, 1, -1);
    check_words("t3", 6, 4);
    check("t3_stable", stable_err, 0);
    check("t3_stalled", stalls > 0, 1);
    @(negedge clk);

    go(3'd0, 4'd0);
    run(20, 0, -1);
    check("t4_done_cyc", dcyc, 0);
    check("t4_sel", sel_seen, 0);
    check("t4_words", n, 0);
    check("t4_dones", dones, 1);
    @(negedge clk);
    check("t4_busy_after", busy, 0);

    go(3'd2, 4'd3);
    run(60, 0, 3);
    check_words("t5", 2, 3);
    @(negedge clk);
    check("t5_no_restart", busy, 0);

    go(3'd0, 4'd12);
    run(80, 0, -1);
    check_words("t6a", 0, 8);
    check("t6a_sel", sel_seen, 8);
    @(negedge clk);

    go(3'd3, 4'd12);
    repeat (7) @(negedge clk);
    check("t6_hold_valid", out_valid, 1);
    check("t6_hold_data", out_data, 8'hA6);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_sel", rom_sel, 0);
    check("t6_rst_addr", rom_address, 0);
    check("t6_rst_last", out_last, 0);
    @(negedge clk);
    check("t6_rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_done", done, 0);
    go(3'd7, 4'd2);
    run(40, 0, -1);
    check_words("t6b", 7, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
